// File: rtl/divider_unit.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, with a
// one-cycle done pulse and held quotient/remainder/divide-by-zero results.
module divider_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] qacc_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_out_q;
  logic             dbz_q;

  logic [WIDTH:0]   shifted_d;
  logic             ge_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] qacc_d;

  // The partial remainder is always below the divisor, so WIDTH bits hold it;
  // only the shifted trial value needs the extra bit for the compare.
  always_comb begin
    shifted_d = {rem_q, qacc_q[WIDTH-1]};
    ge_d      = (shifted_d >= {1'b0, dvsr_q});
    rem_d     = shifted_d[WIDTH-1:0];
    qacc_d    = {qacc_q[WIDTH-2:0], 1'b0};
    if (ge_d) begin
      rem_d  = shifted_d[WIDTH-1:0] - dvsr_q;
      qacc_d = {qacc_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      qacc_q    <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quot_q    <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            if (divisor_i != '0) begin
              dvsr_q  <= divisor_i;
              qacc_q  <= dividend_i;
              rem_q   <= '0;
              cnt_q   <= CW'(WIDTH);
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end else begin
              quot_q    <= '1;
              rem_out_q <= dividend_i;
              dbz_q     <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end
          end
        end
        S_RUN: begin
          rem_q  <= rem_d;
          qacc_q <= qacc_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quot_q    <= qacc_d;
            rem_out_q <= rem_d;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign quotient_o    = quot_q;
  assign remainder_o   = rem_out_q;
  assign div_by_zero_o = dbz_q;

endmodule
